data_mem_responder: RTL and testbench

//   Multi-cycle data-memory responder on the MEM-stage load/store request interface.

---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 185 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// MEM-stage load/store request/response bundle shared by the requester and the data-memory responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: latches one request, waits LATENCY cycles, performs a
// sized little-endian access with sign/zero extension and returns a one-cycle response.
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus,
  output logic [63:0]           dbg_dw0,
  output logic [63:0]           dbg_dw1,
  output logic [63:0]           dbg_dw2,
  output logic [63:0]           dbg_dw3,
  output logic [63:0]           dbg_dw4,
  output logic [63:0]           dbg_dw5,
  output logic [63:0]           dbg_dw6,
  output logic [63:0]           dbg_dw7
);

  localparam int IDXW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic        accept_s, access_s;

  logic        write_r, unsigned_r;
  logic [63:0] addr_r, wdata_r;
  logic [1:0]  size_r;

  logic        ready_r, rsp_valid_r, rsp_err_r;
  logic [63:0] rsp_rdata_r;

  logic [63:0] mem_r [DEPTH];

  logic [IDXW-1:0] idx_s;
  logic [2:0]      off_s;
  logic [63:0]     rd_dw_s, load_s, merged_s;
  logic            err_s;

  // Low 2^size bytes set, used for both store merge and load extraction.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      2'b00:   m = 64'h0000_0000_0000_00FF;
      2'b01:   m = 64'h0000_0000_0000_FFFF;
      2'b10:   m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      2'b10:   bad = (off[1:0] != 2'b00);
      default: bad = (off != 3'b000);
    endcase
    return bad;
  endfunction

  function automatic logic [63:0] store_merge(input logic [63:0] old_dw, input logic [63:0] wdata,
                                              input logic [2:0] off, input logic [1:0] size);
    logic [63:0] lane_mask;
    lane_mask = size_mask(size) << {off, 3'b000};
    return (old_dw & ~lane_mask) | ((wdata & size_mask(size)) << {off, 3'b000});
  endfunction

  function automatic logic [63:0] load_extract(input logic [63:0] dw, input logic [2:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [63:0] raw;
    logic [63:0] ext;
    raw = dw >> {off, 3'b000};
    case (size)
      2'b00:   ext = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'b01:   ext = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'b10:   ext = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
    return ext;
  endfunction

  assign idx_s    = addr_r[IDXW+2:3];
  assign off_s    = addr_r[2:0];
  assign rd_dw_s  = mem_r[idx_s];
  assign err_s    = misaligned(off_s, size_r) | (addr_r[63:3] >= 61'(DEPTH));
  assign load_s   = load_extract(rd_dw_s, off_s, size_r, unsigned_r);
  assign merged_s = store_merge(rd_dw_s, wdata_r, off_s, size_r);

  // Next-state, countdown and access-strobe decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    access_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept_s    = 1'b1;
          cnt_nxt_s   = 4'(LATENCY - 1);
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r != 4'd0) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          access_s    = 1'b1;
          state_nxt_s = ST_RESP;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, request latch and registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      write_r     <= 1'b0;
      unsigned_r  <= 1'b0;
      addr_r      <= 64'd0;
      wdata_r     <= 64'd0;
      size_r      <= 2'b00;
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 64'd0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      ready_r     <= (state_nxt_s == ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
      if (accept_s) begin
        write_r    <= bus.req_write;
        unsigned_r <= bus.req_unsigned;
        addr_r     <= bus.req_addr;
        wdata_r    <= bus.req_wdata;
        size_r     <= bus.req_size;
      end
      // Response data is held until the next access overwrites it.
      if (access_s) begin
        rsp_err_r   <= err_s;
        rsp_rdata_r <= (err_s || write_r) ? 64'd0 : load_s;
      end
    end
  end

  // Storage array; reset wipes it so an in-flight store can never land.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 64'd0;
      end
    end else if (access_s && write_r && !err_s) begin
      mem_r[idx_s] <= merged_s;
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

  assign dbg_dw0 = mem_r[0];
  assign dbg_dw1 = mem_r[1];
  assign dbg_dw2 = mem_r[2];
  assign dbg_dw3 = mem_r[3];
  assign dbg_dw4 = mem_r[4];
  assign dbg_dw5 = mem_r[5];
  assign dbg_dw6 = mem_r[6];
  assign dbg_dw7 = mem_r[7];

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-array reference model predicts each response
// at acceptance; an independent monitor checks responses, latency and req_ready.
module tb_data_mem_responder;
  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] dbg [8];

  exp_t        exp_q[$];
  logic [7:0]  mem_b [DEPTH*8];
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .dbg_dw0(dbg[0]), .dbg_dw1(dbg[1]), .dbg_dw2(dbg[2]), .dbg_dw3(dbg[3]),
    .dbg_dw4(dbg[4]), .dbg_dw5(dbg[5]), .dbg_dw6(dbg[6]), .dbg_dw7(dbg[7])
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH*8; i++) mem_b[i] = 8'h00;
  endfunction

  function automatic logic [63:0] model_dw(input int k);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mem_b[8*k + i];
    return v;
  endfunction

  // Reference behaviour: byte-addressed array, little-endian, extension by size.
  function automatic exp_t model_access(input logic w, input logic [63:0] a, input logic [63:0] wd,
                                        input logic [1:0] sz, input logic u);
    exp_t        e;
    int          nb;
    logic [63:0] v;
    logic [63:0] mask;
    nb      = 1 << sz;
    e.err   = ((a % 64'(nb)) != 64'd0) || (a >= 64'(DEPTH*8));
    e.rdata = 64'd0;
    e.cyc   = 0;
    if (!e.err) begin
      if (w) begin
        for (int i = 0; i < nb; i++) mem_b[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 64'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_b[int'(a) + i];
        mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8*nb)) - 64'd1);
        if (!u && nb != 8 && v[8*nb-1]) v = v | ~mask;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Acceptance monitor: predicts the response when the handshake completes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && bus.req_valid && bus.req_ready) begin
      exp_t e;
      e = model_access(bus.req_write, bus.req_addr, bus.req_wdata, bus.req_size, bus.req_unsigned);
      e.cyc = cyc + 1 + LATENCY;
      exp_q.push_back(e);
    end
  end

  // Response monitor: busy/ready consistency, one response per accept, data and latency.
  always @(negedge clk) begin
    if (reset) begin
      check("req_ready", {63'd0, bus.req_ready}, {63'd0, exp_q.size() == 0});
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("spurious rsp_valid");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err", {63'd0, bus.rsp_err}, {63'd0, e.err});
          check("rsp_latency", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // All driver tasks start and finish just after a falling edge.
  task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] wd,
                       input logic [1:0] sz, input logic u, input logic keep);
    bit done = 1'b0;
    bus.req_write    = w;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_valid    = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      if (bus.req_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) fail_now("accept timeout");
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) fail_now("response timeout");
    @(negedge clk);
  endtask

  task automatic check_rsp(input string name, input logic [63:0] rdata, input logic err);
    check({name, " rdata"}, bus.rsp_rdata, rdata);
    check({name, " err"}, {63'd0, bus.rsp_err}, {63'd0, err});
  endtask

  task automatic check_dbg(input string name);
    for (int k = 0; k < 8; k++) check($sformatf("%s dbg_dw%0d", name, k), dbg[k], model_dw(k));
  endtask

  task automatic check_reset_state(input string name);
    check({name, " req_ready"}, {63'd0, bus.req_ready}, 64'd1);
    check({name, " rsp_valid"}, {63'd0, bus.rsp_valid}, 64'd0);
    check_rsp(name, 64'd0, 1'b0);
    for (int k = 0; k < 8; k++) check($sformatf("%s dbg_dw%0d", name, k), dbg[k], 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    logic [1:0]  sz;
    int          r;
    int          dw;

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 64'd0;
    bus.req_wdata = 64'd0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("reset");

    issue(1'b1, 64'h10, 64'h1122334455667788, 2'b11, 1'b0, 1'b0);
    wait_idle();
    check("store dbl dbg_dw2", dbg[2], 64'h1122334455667788);
    check_rsp("store dbl", 64'd0, 1'b0);

    issue(1'b0, 64'h10, 64'd0, 2'b00, 1'b0, 1'b0); wait_idle();
    check_rsp("lb signed", 64'hFFFF_FFFF_FFFF_FF88, 1'b0);
    issue(1'b0, 64'h10, 64'd0, 2'b00, 1'b1, 1'b0); wait_idle();
    check_rsp("lb unsigned", 64'h88, 1'b0);
    issue(1'b0, 64'h16, 64'd0, 2'b01, 1'b0, 1'b0); wait_idle();
    check_rsp("lh signed", 64'h1122, 1'b0);

    issue(1'b1, 64'h14, 64'hDEADBEEF, 2'b10, 1'b0, 1'b0); wait_idle();
    check("sw dbg_dw2", dbg[2], 64'hDEADBEEF55667788);
    issue(1'b0, 64'h14, 64'd0, 2'b10, 1'b0, 1'b0); wait_idle();
    check_rsp("lw signed", 64'hFFFF_FFFF_DEAD_BEEF, 1'b0);

    issue(1'b0, 64'h12, 64'd0, 2'b10, 1'b0, 1'b0); wait_idle();
    check_rsp("lw misaligned", 64'd0, 1'b1);
    issue(1'b1, 64'(DEPTH*8), 64'hA5A5_A5A5_A5A5_A5A5, 2'b11, 1'b0, 1'b0); wait_idle();
    check_rsp("sd out of range", 64'd0, 1'b1);
    check_dbg("after oor store");

    // Back-to-back with req_valid held high; fields change right after each accept.
    for (int i = 0; i < 8; i++) begin
      issue(i[0] ? 1'b0 : 1'b1, 64'(8 * (i % 4)), {$urandom, $urandom}, 2'(i % 4),
            1'($urandom_range(0, 1)), (i != 7) ? 1'b1 : 1'b0);
    end
    wait_idle();
    check_dbg("after back-to-back");

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      sz = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      dw = $urandom_range(0, ($urandom_range(0, 3) == 0) ? DEPTH - 1 : 7);
      if (r < 7) begin
        a = 64'(dw * 8) + (64'($urandom_range(0, 7)) & ~((64'd1 << sz) - 64'd1));
      end else if (r == 7) begin
        a = 64'(dw * 8) + 64'($urandom_range(0, 7) | 1);
      end else if (r == 8) begin
        a = 64'(DEPTH*8) + 64'($urandom_range(0, 255));
      end else begin
        a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      end
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, sz, 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    check_dbg("after random");

    // Reset while a store to 0x08 is in flight: it must never land or respond.
    issue(1'b1, 64'h08, 64'hCAFEF00D_12345678, 2'b11, 1'b0, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    model_clear();
    @(negedge clk);
    check_reset_state("mid-flight reset");
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("post-reset dbg_dw1", dbg[1], 64'd0);
    issue(1'b0, 64'h08, 64'd0, 2'b11, 1'b0, 1'b0); wait_idle();
    check_rsp("post-reset ld", 64'd0, 1'b0);

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
endmodule
